// File: rtl/cs015p.sv
// cs015p: 4-bit synchronous up-counter with per-bit asynchronous clear/preset.
// Each bit is a toggle flop. The enable for bit i is the AND of all lower bits,
// so every bit changes on the same clk edge and Q never shows a rippled value.
// Optional build macro CS015P_TC_EN adds a terminal-count output tc after clk.

module cs015p_tff (
  input  logic clk,
  input  logic clr_n,
  input  logic set_n,
  input  logic t,
  output logic q
);
  // Clear dominates preset; otherwise toggle on the edge when enabled.
  always_ff @(posedge clk or negedge clr_n or negedge set_n) begin
    if (!clr_n)      q <= 1'b0;
    else if (!set_n) q <= 1'b1;
    else if (t)      q <= ~q;
  end
endmodule

module cs015p #(
  parameter int WIDTH = 4
) (
  input  logic             PR,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  input  logic             clk
`ifdef CS015P_TC_EN
  ,
  output logic             tc
`endif
);

  // The preset seen by the flops is gated by CLR. Releasing CLR while PR is
  // still low therefore produces a falling edge on set_n, and the counter
  // jumps to all ones at once instead of waiting for the next clk edge.
  logic set_n;
  assign set_n = PR | ~CLR;

  // Ripple-carry toggle enables: en[0]=1, en[i+1] = en[i] & Q[i].
  logic [WIDTH:0] en;
  assign en[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign en[i+1] = en[i] & Q[i];
      cs015p_tff u_tff (
        .clk   (clk),
        .clr_n (CLR),
        .set_n (set_n),
        .t     (en[i]),
        .q     (Q[i])
      );
    end
  endgenerate

`ifdef CS015P_TC_EN
  // Terminal count: all ones and not being cleared. Also high during preset.
  assign tc = CLR & en[WIDTH];
`endif

endmodule

// File: tb/tb_cs015p.sv
// Self-checking bench for cs015p. Expected counts come from a bench-side
// model and go through a queue; each sample pops one value and compares.
`timescale 1ns/1ps

module tb_cs015p;
  logic       clk;
  logic       PR;
  logic       CLR;
  logic [3:0] Q;
`ifdef CS015P_TC_EN
  logic       tc;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mdl;

  cs015p #(.WIDTH(4)) dut (
    .PR  (PR),
    .CLR (CLR),
    .Q   (Q),
    .clk (clk)
`ifdef CS015P_TC_EN
    ,
    .tc  (tc)
`endif
  );

  // 20 ns period, clk starts low, rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] v);
    exp_q.push_back(v);
  endtask

  // Pop the next expected count and compare Q (and tc when built in).
  task automatic sample(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {28'd0, Q}, {28'd0, e});
`ifdef CS015P_TC_EN
      chk({tag, "_tc"}, {31'd0, tc}, {31'd0, (CLR === 1'b1) && (e == 4'd15)});
`endif
    end
  endtask

  task automatic edge_count(input string tag);
    @(posedge clk); #1;
    mdl = mdl + 4'd1;
    push(mdl);
    sample(tag);
  endtask

  initial begin
    PR  = 1'b1;
    CLR = 1'b0;
    mdl = 4'd0;

    // Reset held across the first edge.
    #5;  push(4'd0); sample("rst");
    #10; push(4'd0); sample("rst_edge");
    #5;  CLR = 1'b1;                          // t = 20

    // Full count 1..15 then wrap to 0 (edge at 330 ns).
    for (int k = 0; k < 16; k++) edge_count("count");
    chk("wrap_val", {28'd0, Q}, 32'd0);

    // Advance to 7, then pulse CLR between edges.
    while (mdl != 4'd7) edge_count("to7");
    #5; CLR = 1'b0;
    #1; mdl = 4'd0; push(mdl); sample("midclr");
    #2; CLR = 1'b1;
    edge_count("after_clr");

    // Preset between edges, held across an edge, then released.
    #5; PR = 1'b0;
    #1; mdl = 4'd15; push(mdl); sample("preset");
    @(posedge clk); #1; push(mdl); sample("preset_hold");
    #3; PR = 1'b1;
    edge_count("after_pr");

    // Both asserted: clear wins; release CLR with PR still low -> 15.
    #3; PR = 1'b0; CLR = 1'b0;
    #1; mdl = 4'd0; push(mdl); sample("both");
    @(posedge clk); #1; push(mdl); sample("both_hold");
    #2; CLR = 1'b1;
    #1; mdl = 4'd15; push(mdl); sample("clr_rel_pr");
    #1; PR = 1'b1;
    edge_count("rel_wrap");
    edge_count("tail1");
    edge_count("tail2");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
